// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Data-memory responder for the single-cycle RV32 core. Word-organised RAM
// with byte-lane stores and combinational word reads, plus a small MMIO
// window (64-bit cycle counter, committed-store counter, LED register and a
// sticky misaligned-store error register).
//
// Ports
//   CLK         in   1  clock, all state updates on the rising edge
//   RST         in   1  synchronous active-high reset
//   D_OUT       in  32  store data, right-justified
//   D_OUT_ADDR  in  32  store byte address
//   WR          in   2  store size: 00 none, 01 byte, 10 half, 11 word
//   D_IN_ADDR   in  32  load byte address
//   D_IN        out 32  aligned word containing D_IN_ADDR (combinational)
//   LEDS        out  8  LED register
//   ERR         out  1  sticky misaligned-store flag
//   ERR_ADDR    out 32  address of first misaligned store since last clear
// -----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] D_OUT,
    input  logic [31:0] D_OUT_ADDR,
    input  logic [1:0]  WR,
    input  logic [31:0] D_IN_ADDR,
    output logic [31:0] D_IN,
    output logic [7:0]  LEDS,
    output logic        ERR,
    output logic [31:0] ERR_ADDR
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned IDX_HI = AW + 1;
    localparam int unsigned RAM_HI = AW + 2;

    localparam logic [5:0] REG_CYCLE_LO = 6'd0;
    localparam logic [5:0] REG_CYCLE_HI = 6'd1;
    localparam logic [5:0] REG_LED      = 6'd2;
    localparam logic [5:0] REG_STATUS   = 6'd3;
    localparam logic [5:0] REG_STCOUNT  = 6'd4;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    logic [31:0] cycle_lo_q, cycle_lo_d;
    logic [31:0] cycle_hi_q, cycle_hi_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [7:0]  led_q, led_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // -------------------------------------------------------------------------
    // Store-side decode
    // -------------------------------------------------------------------------
    logic          st_ram_hit_c;
    logic          st_mmio_hit_c;
    logic          st_mapped_c;
    logic [5:0]    st_reg_c;
    logic [AW-1:0] st_idx_c;
    logic          st_aligned_c;
    logic [3:0]    lane_mask_c;
    logic [31:0]   lane_data_c;
    logic          st_req_c;
    logic          st_commit_c;
    logic          st_misalign_c;
    logic          mem_we_c;
    logic          led_we_c;
    logic          err_clr_c;

    // RAM occupies the bottom DEPTH*4 bytes; any set upper bit is outside it.
    assign st_ram_hit_c  = (D_OUT_ADDR[31:RAM_HI] == '0);
    assign st_mmio_hit_c = (D_OUT_ADDR[31:8] == MMIO_BASE[31:8]) && !st_ram_hit_c;
    assign st_mapped_c   = st_ram_hit_c || st_mmio_hit_c;
    assign st_reg_c      = D_OUT_ADDR[7:2];
    assign st_idx_c      = D_OUT_ADDR[IDX_HI:2];

    // Size-dependent alignment, lane enables and lane-replicated write data.
    always_comb begin
        st_aligned_c = 1'b0;
        lane_mask_c  = 4'b0000;
        lane_data_c  = D_OUT;
        case (WR)
            WR_BYTE: begin
                st_aligned_c = 1'b1;
                lane_mask_c  = 4'b0001 << D_OUT_ADDR[1:0];
                lane_data_c  = {4{D_OUT[7:0]}};
            end
            WR_HALF: begin
                st_aligned_c = !D_OUT_ADDR[0];
                lane_mask_c  = D_OUT_ADDR[1] ? 4'b1100 : 4'b0011;
                lane_data_c  = {2{D_OUT[15:0]}};
            end
            WR_WORD: begin
                st_aligned_c = (D_OUT_ADDR[1:0] == 2'b00);
                lane_mask_c  = 4'b1111;
                lane_data_c  = D_OUT;
            end
            default: begin
                st_aligned_c = 1'b0;
                lane_mask_c  = 4'b0000;
                lane_data_c  = D_OUT;
            end
        endcase
    end

    // A store asserted together with reset is dropped entirely.
    assign st_req_c      = (WR != WR_NONE) && !RST;
    assign st_commit_c   = st_req_c && st_mapped_c && st_aligned_c;
    assign st_misalign_c = st_req_c && st_mapped_c && !st_aligned_c;

    assign mem_we_c  = st_commit_c && st_ram_hit_c;
    // LED and STATUS live in lane 0 of their word; other lanes are ignored.
    assign led_we_c  = st_commit_c && st_mmio_hit_c && (st_reg_c == REG_LED)
                       && lane_mask_c[0];
    assign err_clr_c = st_commit_c && st_mmio_hit_c && (st_reg_c == REG_STATUS)
                       && lane_mask_c[0] && lane_data_c[0];

    // -------------------------------------------------------------------------
    // Next-state logic for the MMIO registers
    // -------------------------------------------------------------------------
    always_comb begin
        cycle_lo_d  = cycle_lo_q + 32'd1;
        cycle_hi_d  = cycle_hi_q;
        store_cnt_d = store_cnt_q;
        led_d       = led_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;

        // Carry into the high half on the edge the low half wraps.
        if (cycle_lo_q == 32'hFFFF_FFFF) begin
            cycle_hi_d = cycle_hi_q + 32'd1;
        end

        if (st_commit_c) begin
            store_cnt_d = store_cnt_q + 32'd1;
        end

        if (led_we_c) begin
            led_d = lane_data_c[7:0];
        end

        if (err_clr_c) begin
            err_d = 1'b0;
        end

        // Only the first misaligned store since the last clear is recorded.
        if (st_misalign_c) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = D_OUT_ADDR;
            end
        end
    end

    // Register bank with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_lo_q  <= '0;
            cycle_hi_q  <= '0;
            store_cnt_q <= '0;
            led_q       <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            cycle_lo_q  <= cycle_lo_d;
            cycle_hi_q  <= cycle_hi_d;
            store_cnt_q <= store_cnt_d;
            led_q       <= led_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // RAM byte-lane write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask_c[i]) begin
                    mem_q[st_idx_c][8*i +: 8] <= lane_data_c[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load path (combinational, sees pre-edge state)
    // -------------------------------------------------------------------------
    logic          rd_ram_hit_c;
    logic          rd_mmio_hit_c;
    logic [AW-1:0] rd_idx_c;
    logic [5:0]    rd_reg_c;
    logic          unused_rd_lsbs;

    assign rd_ram_hit_c  = (D_IN_ADDR[31:RAM_HI] == '0);
    assign rd_mmio_hit_c = (D_IN_ADDR[31:8] == MMIO_BASE[31:8]) && !rd_ram_hit_c;
    assign rd_idx_c      = D_IN_ADDR[IDX_HI:2];
    assign rd_reg_c      = D_IN_ADDR[7:2];
    // Loads always return the full word; byte offset is not needed here.
    assign unused_rd_lsbs = ^D_IN_ADDR[1:0];

    always_comb begin
        D_IN = '0;
        if (rd_ram_hit_c) begin
            D_IN = mem_q[rd_idx_c];
        end else if (rd_mmio_hit_c) begin
            case (rd_reg_c)
                REG_CYCLE_LO: D_IN = cycle_lo_q;
                REG_CYCLE_HI: D_IN = cycle_hi_q;
                REG_LED:      D_IN = {24'd0, led_q};
                REG_STATUS:   D_IN = {31'd0, err_q};
                REG_STCOUNT:  D_IN = store_cnt_q;
                default:      D_IN = '0;
            endcase
        end
    end

    assign LEDS     = led_q;
    assign ERR      = err_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int unsigned NBYTE = DEPTH * 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] D_OUT = '0;
    logic [31:0] D_OUT_ADDR = '0;
    logic [1:0]  WR = '0;
    logic [31:0] D_IN_ADDR = '0;
    logic [31:0] D_IN;
    logic [7:0]  LEDS;
    logic        ERR;
    logic [31:0] ERR_ADDR;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, byte-addressed.
    logic [7:0]  m_mem [NBYTE];
    logic [63:0] m_cycle = '0;
    logic [31:0] m_count = '0;
    logic [7:0]  m_led = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_err_addr = '0;

    data_mem_resp #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .D_OUT      (D_OUT),
        .D_OUT_ADDR (D_OUT_ADDR),
        .WR         (WR),
        .D_IN_ADDR  (D_IN_ADDR),
        .D_IN       (D_IN),
        .LEDS       (LEDS),
        .ERR        (ERR),
        .ERR_ADDR   (ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    function automatic logic is_mmio(input logic [31:0] a);
        return (a >> 8) == (BASE >> 8);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a < NBYTE) return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
        if (is_mmio(a)) begin
            case (a[7:0])
                8'h00:   return m_cycle[31:0];
                8'h04:   return m_cycle[63:32];
                8'h08:   return {24'd0, m_led};
                8'h0C:   return {31'd0, m_err};
                8'h10:   return m_count;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // Apply one rising edge to the model from the inputs presented before it.
    task automatic model_edge(input logic rst, input logic [1:0] wr,
                              input logic [31:0] addr, input logic [31:0] data);
        int size;
        logic [7:0] b;
        logic [7:0] off;
        if (rst) begin
            m_cycle = '0; m_count = '0; m_led = '0; m_err = 1'b0; m_err_addr = '0;
            return;
        end
        m_cycle = m_cycle + 64'd1;
        if (wr == 2'b00) return;
        size = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
        if (!(addr < NBYTE) && !is_mmio(addr)) return;
        if ((addr % size) != 0) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
            return;
        end
        m_count = m_count + 32'd1;
        for (int i = 0; i < size; i++) begin
            b = data[8*i +: 8];
            if (addr < NBYTE) begin
                m_mem[addr + 32'(i)] = b;
            end else begin
                off = 8'(addr[7:0] + 8'(i));
                if (off == 8'h08) m_led = b;
                if (off == 8'h0C && b[0]) m_err = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] wr, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] raddr);
        RST = rst; WR = wr; D_OUT_ADDR = waddr; D_OUT = wdata; D_IN_ADDR = raddr;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge(RST, WR, D_OUT_ADDR, D_OUT);
        #1;
        RST = 1'b0; WR = 2'b00;
    endtask

    task automatic store(input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, wr, addr, data, D_IN_ADDR);
        tick();
    endtask

    task automatic set_raddr(input logic [31:0] a);
        D_IN_ADDR = a;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 255));
            6, 7, 8:          return BASE + 32'($urandom_range(0, 31));
            default:          return 32'h8000_0000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        drive(1'b1, 2'b00, 32'd0, 32'd0, BASE);
        tick(); drive(1'b1, 2'b00, 32'd0, 32'd0, BASE);
        tick(); drive(1'b1, 2'b00, 32'd0, 32'd0, BASE);
        tick();
        set_raddr(BASE);
        tests_run++;
        if (D_IN !== 32'd0) begin tests_failed++; $display("FAIL reset_cycle_lo: got %h expected %h", D_IN, 32'd0); end
        tests_run++;
        if (LEDS !== 8'd0) begin tests_failed++; $display("FAIL reset_leds: got %h expected %h", LEDS, 8'd0); end
        tests_run++;
        if (ERR !== 1'b0 || ERR_ADDR !== 32'd0) begin tests_failed++; $display("FAIL reset_err: got %b/%h expected 0/0", ERR, ERR_ADDR); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== 32'd0) begin tests_failed++; $display("FAIL reset_store_count: got %h expected %h", D_IN, 32'd0); end
    endtask

    task automatic test_cycle_counter();
        for (int i = 0; i < 10; i++) tick();
        set_raddr(BASE);
        tests_run++;
        if (D_IN !== 32'd10) begin tests_failed++; $display("FAIL cycle_lo_10: got %h expected %h", D_IN, 32'd10); end
        set_raddr(BASE + 32'h4);
        tests_run++;
        if (D_IN !== 32'd0) begin tests_failed++; $display("FAIL cycle_hi_0: got %h expected %h", D_IN, 32'd0); end
        dut.cycle_lo_q = 32'hFFFF_FFFF;
        m_cycle[31:0] = 32'hFFFF_FFFF;
        tick();
        set_raddr(BASE);
        tests_run++;
        if (D_IN !== 32'd0) begin tests_failed++; $display("FAIL cycle_wrap_lo: got %h expected %h", D_IN, 32'd0); end
        set_raddr(BASE + 32'h4);
        tests_run++;
        if (D_IN !== 32'd1) begin tests_failed++; $display("FAIL cycle_wrap_hi: got %h expected %h", D_IN, 32'd1); end
    endtask

    task automatic test_init_ram();
        for (int i = 0; i < 64; i++) store(2'b11, 32'(i * 4), $urandom);
        for (int i = 0; i < 4; i++) begin
            set_raddr(32'($urandom_range(0, 255)));
            tests_run++;
            if (D_IN !== model_read(D_IN_ADDR)) begin tests_failed++; $display("FAIL init_readback @%h: got %h expected %h", D_IN_ADDR, D_IN, model_read(D_IN_ADDR)); end
        end
    endtask

    task automatic test_word_store();
        logic [31:0] c0;
        c0 = m_count;
        store(2'b11, 32'h10, 32'hDEAD_BEEF);
        set_raddr(32'h10);
        tests_run++;
        if (D_IN !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_load_10: got %h expected %h", D_IN, 32'hDEAD_BEEF); end
        set_raddr(32'h13);
        tests_run++;
        if (D_IN !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_load_13: got %h expected %h", D_IN, 32'hDEAD_BEEF); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== c0 + 32'd1) begin tests_failed++; $display("FAIL word_store_count: got %h expected %h", D_IN, c0 + 32'd1); end
    endtask

    task automatic test_lane_merge();
        store(2'b01, 32'h11, 32'hFFFF_FF55);
        set_raddr(32'h10);
        tests_run++;
        if (D_IN !== 32'hDEAD_55EF) begin tests_failed++; $display("FAIL byte_merge: got %h expected %h", D_IN, 32'hDEAD_55EF); end
        drive(1'b0, 2'b10, 32'h12, 32'hABCD_1234, 32'h10);
        tests_run++;
        if (D_IN !== 32'hDEAD_55EF) begin tests_failed++; $display("FAIL read_during_write: got %h expected %h", D_IN, 32'hDEAD_55EF); end
        tick();
        tests_run++;
        if (D_IN !== 32'h1234_55EF) begin tests_failed++; $display("FAIL half_merge: got %h expected %h", D_IN, 32'h1234_55EF); end
    endtask

    task automatic test_misaligned();
        logic [31:0] old20, c0;
        old20 = model_read(32'h20);
        c0 = m_count;
        store(2'b10, 32'h21, $urandom);
        tests_run++;
        if (ERR !== 1'b1 || ERR_ADDR !== 32'h21) begin tests_failed++; $display("FAIL misalign_half: got %b/%h expected 1/00000021", ERR, ERR_ADDR); end
        set_raddr(32'h20);
        tests_run++;
        if (D_IN !== old20) begin tests_failed++; $display("FAIL misalign_ram_unchanged: got %h expected %h", D_IN, old20); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== c0) begin tests_failed++; $display("FAIL misalign_no_count: got %h expected %h", D_IN, c0); end
        store(2'b11, 32'h32, $urandom);
        tests_run++;
        if (ERR !== 1'b1 || ERR_ADDR !== 32'h21) begin tests_failed++; $display("FAIL misalign_sticky: got %b/%h expected 1/00000021", ERR, ERR_ADDR); end
        store(2'b11, BASE + 32'h0C, 32'd1);
        tests_run++;
        if (ERR !== 1'b0 || ERR_ADDR !== 32'h21) begin tests_failed++; $display("FAIL err_clear: got %b/%h expected 0/00000021", ERR, ERR_ADDR); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== c0 + 32'd1) begin tests_failed++; $display("FAIL clear_counts: got %h expected %h", D_IN, c0 + 32'd1); end
    endtask

    task automatic test_led_unmapped();
        logic [31:0] c0;
        store(2'b01, BASE + 32'h08, 32'h0000_00A5);
        set_raddr(BASE + 32'h08);
        tests_run++;
        if (LEDS !== 8'hA5 || D_IN !== 32'h0000_00A5) begin tests_failed++; $display("FAIL led_write: got %h/%h expected a5/000000a5", LEDS, D_IN); end
        c0 = m_count;
        store(2'b11, 32'h8000_0000, 32'hCAFE_F00D);
        set_raddr(32'h8000_0000);
        tests_run++;
        if (ERR !== 1'b0 || D_IN !== 32'd0) begin tests_failed++; $display("FAIL unmapped: got err=%b data=%h expected 0/0", ERR, D_IN); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== c0) begin tests_failed++; $display("FAIL unmapped_no_count: got %h expected %h", D_IN, c0); end
        store(2'b11, BASE + 32'h10, 32'h0);
        tests_run++;
        if (D_IN !== c0 + 32'd1) begin tests_failed++; $display("FAIL count_self_store: got %h expected %h", D_IN, c0 + 32'd1); end
    endtask

    task automatic test_reset_store();
        logic [31:0] old40;
        store(2'b01, BASE + 32'h08, 32'h3C);
        tests_run++;
        if (LEDS !== 8'h3C) begin tests_failed++; $display("FAIL led_3c: got %h expected %h", LEDS, 8'h3C); end
        old40 = model_read(32'h40);
        drive(1'b1, 2'b11, 32'h40, 32'hFF, 32'h40);
        tick();
        set_raddr(32'h40);
        tests_run++;
        if (D_IN !== old40) begin tests_failed++; $display("FAIL reset_store_ram: got %h expected %h", D_IN, old40); end
        tests_run++;
        if (LEDS !== 8'd0 || ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_store_regs: got %h/%b expected 00/0", LEDS, ERR); end
        set_raddr(BASE + 32'h10);
        tests_run++;
        if (D_IN !== 32'd0) begin tests_failed++; $display("FAIL reset_store_count: got %h expected %h", D_IN, 32'd0); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), rand_addr(),
                  $urandom, rand_addr());
            exp = model_read(D_IN_ADDR);
            tests_run++;
            if (D_IN !== exp) begin tests_failed++; $display("FAIL rand_load[%0d] @%h: got %h expected %h", n, D_IN_ADDR, D_IN, exp); end
            tick();
            tests_run++;
            if (LEDS !== m_led || ERR !== m_err || ERR_ADDR !== m_err_addr) begin
                tests_failed++;
                $display("FAIL rand_regs[%0d]: got %h/%b/%h expected %h/%b/%h", n, LEDS, ERR, ERR_ADDR, m_led, m_err, m_err_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cycle_counter();
        test_init_ram();
        test_word_store();
        test_lane_merge();
        test_misaligned();
        test_led_unmapped();
        test_reset_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
